// File: rtl/hazard_ctrl.sv
// Issue-side hazard controller: turns the register file's pause code and EX
// redirects into PC/IF-ID/ID-EX controls, with stall statistics and a watchdog.
module hazard_ctrl #(
  parameter int MAX_STALL = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_wb,
  input  logic [4:0]       id_dest,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [1:0]       pause,
  input  logic             branch_taken,
  output logic [4:0]       collision_addr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stalling,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] stall_events,
  output logic             hazard_err
);

  localparam int RL_W = $clog2(MAX_STALL + 2);
  localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  events_q, events_d;
  logic [RL_W-1:0]   runLen_q, runLen_d;
  logic              err_q, err_d;

  logic hazard;
  logic stallCycle;

  // A pause on an operand the instruction does not read is ignored.
  assign hazard     = id_valid & ((pause[0] & id_uses_rs) | (pause[1] & id_uses_rt));
  assign stallCycle = hazard & ~branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      cycles_q <= '0;
      events_q <= '0;
      runLen_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      events_q <= events_d;
      runLen_q <= runLen_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stallCycle) state_d = STALL;
      STALL:   if (!stallCycle) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Statistics saturate rather than wrap; an episode starts on RUN -> STALL.
  always_comb begin
    cycles_d = cycles_q;
    events_d = events_q;
    runLen_d = '0;
    if (stallCycle) begin
      if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
      if (state_q == RUN && events_q != '1) events_d = events_q + 1'b1;
      runLen_d = (runLen_q == RL_MAX) ? RL_MAX : runLen_q + 1'b1;
    end
    err_d = err_q | (runLen_d == RL_MAX);
  end

  // Bubbles must never issue a destination, or the scoreboard would not drain.
  always_comb begin
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    collision_addr = (id_valid & id_wb) ? id_dest : 5'd0;
    if (branch_taken) begin
      ifid_flush     = 1'b1;
      idex_bubble    = 1'b1;
      collision_addr = 5'd0;
    end else if (hazard) begin
      pc_we          = 1'b0;
      ifid_we        = 1'b0;
      idex_bubble    = 1'b1;
      collision_addr = 5'd0;
    end
  end

  assign stalling     = (state_q == STALL);
  assign stall_cycles = cycles_q;
  assign stall_events = events_q;
  assign hazard_err   = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, compared against an episode/counter model of the pipeline rules.
module tb_hazard_ctrl;

  localparam int MAX_STALL = 3;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic             id_wb;
  logic [4:0]       id_dest;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [1:0]       pause;
  logic             branch_taken;
  logic [4:0]       collision_addr;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             stalling;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] stall_events;
  logic             hazard_err;

  int assertCount;
  int failCount;

  // Reference model state: totals, whether last cycle stalled, current streak.
  int mCycles;
  int mEvents;
  int mStreak;
  bit mPrevStall;
  bit mErr;

  hazard_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_wb(id_wb), .id_dest(id_dest),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .pause(pause), .branch_taken(branch_taken),
    .collision_addr(collision_addr), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .stalling(stalling),
    .stall_cycles(stall_cycles), .stall_events(stall_events), .hazard_err(hazard_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit wb, input int dest,
                               input bit rs, input bit rt, input int p, input bit br);
    id_valid     = v;
    id_wb        = wb;
    id_dest      = 5'(dest);
    id_uses_rs   = rs;
    id_uses_rt   = rt;
    pause        = 2'(p);
    branch_taken = br;
  endtask

  task automatic resetModel();
    mCycles = 0; mEvents = 0; mStreak = 0; mPrevStall = 0; mErr = 0;
  endtask

  task automatic checkRegistered(input string tag);
    checkOutput({tag, ".stalling"}, int'(stalling), int'(mPrevStall));
    checkOutput({tag, ".stall_cycles"}, int'(stall_cycles), mCycles);
    checkOutput({tag, ".stall_events"}, int'(stall_events), mEvents);
    checkOutput({tag, ".hazard_err"}, int'(hazard_err), int'(mErr));
  endtask

  // Called at posedge+1 with inputs applied; checks controls, clocks, checks state.
  task automatic runCycle(input string tag);
    bit hz, isStall;
    int ePc, eIfid, eFlush, eBub, eAddr;
    #1;
    hz = id_valid && ((pause[0] && id_uses_rs) || (pause[1] && id_uses_rt));
    if (branch_taken) begin
      ePc = 1; eIfid = 1; eFlush = 1; eBub = 1; eAddr = 0;
    end else if (hz) begin
      ePc = 0; eIfid = 0; eFlush = 0; eBub = 1; eAddr = 0;
    end else begin
      ePc = 1; eIfid = 1; eFlush = 0; eBub = 0;
      eAddr = (id_valid && id_wb) ? int'(id_dest) : 0;
    end
    checkOutput({tag, ".pc_we"}, int'(pc_we), ePc);
    checkOutput({tag, ".ifid_we"}, int'(ifid_we), eIfid);
    checkOutput({tag, ".ifid_flush"}, int'(ifid_flush), eFlush);
    checkOutput({tag, ".idex_bubble"}, int'(idex_bubble), eBub);
    checkOutput({tag, ".collision_addr"}, int'(collision_addr), eAddr);
    isStall = hz && !branch_taken;
    @(posedge clk);
    if (isStall) begin
      if (mCycles < CNT_MAX) mCycles++;
      if (!mPrevStall && mEvents < CNT_MAX) mEvents++;
      mStreak++;
      if (mStreak > MAX_STALL) mErr = 1;
    end else begin
      mStreak = 0;
    end
    mPrevStall = isStall;
    #1;
    checkRegistered(tag);
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic asyncReset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    resetModel();
    checkRegistered(tag);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    resetModel();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkRegistered("reset");
    checkOutput("reset.pc_we", int'(pc_we), 1);
    checkOutput("reset.ifid_we", int'(ifid_we), 1);
    checkOutput("reset.ifid_flush", int'(ifid_flush), 0);
    checkOutput("reset.idex_bubble", int'(idex_bubble), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Producer writes r5, consumer reads r5 and is paused for three cycles.
    applyStimulus(1, 1, 5, 0, 0, 0, 0);
    runCycle("producer");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 7, 1, 0, 1, 0);
      runCycle("raw_stall");
    end
    applyStimulus(1, 1, 7, 1, 0, 0, 0);
    runCycle("raw_release");
    checkOutput("raw.total_cycles", int'(stall_cycles), 3);
    checkOutput("raw.total_events", int'(stall_events), 1);

    // Pause on an operand the instruction does not read.
    applyStimulus(1, 1, 9, 1, 0, 2, 0);
    runCycle("unused_rt");
    checkOutput("unused_rt.cycles_kept", int'(stall_cycles), 3);

    // Branch in the same cycle as a full hazard.
    applyStimulus(1, 1, 11, 1, 1, 3, 1);
    runCycle("branch_hazard");
    checkOutput("branch_hazard.cycles_kept", int'(stall_cycles), 3);

    // Reset landing in the middle of a stall episode.
    applyStimulus(1, 0, 0, 1, 0, 1, 0);
    runCycle("pre_reset_stall");
    applyStimulus(1, 0, 0, 1, 0, 1, 0);
    asyncReset("midstall_reset");

    // Four consecutive stall cycles trip the watchdog, which stays set.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 3, 1, 0, 1, 0);
      runCycle("watchdog");
    end
    checkOutput("watchdog.err_set", int'(hazard_err), 1);
    applyStimulus(1, 1, 3, 1, 0, 0, 0);
    runCycle("watchdog_clear");
    checkOutput("watchdog.err_sticky", int'(hazard_err), 1);

    // Twelve more stall cycles push the 4-bit total past its ceiling.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 2, 0);
      runCycle("saturate");
    end
    checkOutput("saturate.cycles_held", int'(stall_cycles), CNT_MAX);
    checkOutput("saturate.events", int'(stall_events), 2);

    asyncReset("pre_random_reset");

    // Random traffic with hazards biased to form short episodes.
    for (int i = 0; i < 120; i++) begin
      applyStimulus(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 5) == 0));
      runCycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Issue-side counterpart to the register file's collision scoreboard.
- Sits between ID and the pipeline registers:
  - drives `collision_addr` (the destination of each issued instruction) into the register file;
  - consumes the resulting `pause` code;
  - converts it, together with EX branch redirects, into PC/IF-ID hold, IF-ID flush and ID-EX bubble controls;
  - keeps stall statistics and a stuck-stall watchdog.

## Interface
Parameters:
- `MAX_STALL`, 3: longest legal run of consecutive stall cycles. One more raises `hazard_err`.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_wb` in 1: ID instruction writes the register file.
- `id_dest` in 5: ID instruction destination register.
- `id_uses_rs` in 1: ID instruction reads rs.
- `id_uses_rt` in 1: ID instruction reads rt.
- `pause` in 2: register-file hazard code.
  - bit0 = rs, bit1 = rt.
  - NO=2'b00, RS=2'b01, RT=2'b10, BOTH=2'b11.
- `branch_taken` in 1: EX redirect this cycle.
- `collision_addr` out 5: destination issued into the scoreboard this cycle; 0 = nothing.
- `pc_we` out 1: PC update enable.
- `ifid_we` out 1: IF/ID register load enable.
- `ifid_flush` out 1: clear IF/ID to NOP.
- `idex_bubble` out 1: load NOP into ID/EX.
- `stalling` out 1: registered; high while in STALL state.
- `stall_cycles` out CNT_W: total stall cycles, saturating.
- `stall_events` out CNT_W: number of distinct stall episodes, saturating.
- `hazard_err` out 1: sticky watchdog flag.

## Operation
- `hazard` = `id_valid` & ((`pause[0]` & `id_uses_rs`) | (`pause[1]` & `id_uses_rt`)). A pause on an unused operand is ignored.
- Combinational controls, in priority order:
  - `branch_taken`: `pc_we`=1, `ifid_we`=1, `ifid_flush`=1, `idex_bubble`=1, `collision_addr`=0. Branch wins over hazard; the stalled ID instruction is wrong-path.
  - `hazard`: `pc_we`=0, `ifid_we`=0, `ifid_flush`=0, `idex_bubble`=1, `collision_addr`=0.
  - otherwise: `pc_we`=1, `ifid_we`=1, `ifid_flush`=0, `idex_bubble`=0, `collision_addr` = (`id_valid`&`id_wb`) ? `id_dest` : 0.
- `collision_addr` must be 0 on every bubble, otherwise the scoreboard never drains.
- State machine (registered, 2 states):
  - RUN → STALL when `hazard` & !`branch_taken`. `stall_events` += 1.
  - STALL → STALL while `hazard` & !`branch_taken`.
  - STALL → RUN when !`hazard` or `branch_taken`.
- Counters:
  - `stall_cycles` += 1 on every cycle with `hazard` & !`branch_taken`.
  - Both statistics counters saturate at all-ones; no wrap.
- Watchdog:
  - `run_len` counts consecutive stall cycles; cleared on any non-stall cycle.
  - When `run_len` reaches `MAX_STALL`+1, `hazard_err` is set.
  - `hazard_err` stays set until reset.
  - `run_len` saturates at `MAX_STALL`+1.

## Timing
- Reset values:
  - state RUN, `stalling`=0, `stall_cycles`=0, `stall_events`=0, `hazard_err`=0, `run_len`=0.
  - Combinational outputs then follow their inputs (with `pause`=00, `branch_taken`=0: `pc_we`=`ifid_we`=1, flush and bubble 0).
- Control outputs have zero latency: same cycle as `pause`/`branch_taken`.
- Statistics, `stalling` and `hazard_err` update on the edge ending the cycle, so they are visible one cycle later.
- RAW against the scoreboard's 3-deep history gives a stall of at most 3 cycles. With `MAX_STALL`=3, a 4th consecutive stall cycle sets `hazard_err` at the end of that cycle.
- Reset asserted mid-stall: state returns to RUN immediately (asynchronous); counters clear; no further bubbles are attributed.
- `branch_taken` in the same cycle as `hazard`: not counted as a stall; ends any STALL episode.

## Test plan
- Producer `id_dest`=5, `id_wb`=1, then consumer reading rs=5, so `pause` is 01 for 3 cycles.
  - Expect 3 cycles of `pc_we`=0, `idex_bubble`=1, `collision_addr`=0.
  - Then `stall_cycles`=3, `stall_events`=1.
- `pause`=10 with `id_uses_rt`=0 → no stall, `collision_addr`=`id_dest`, counters unchanged.
- `pause`=11 and `branch_taken`=1 in the same cycle → `ifid_flush`=1, `pc_we`=1, `collision_addr`=0, `stall_cycles` unchanged.
- Hold `pause`=01 with `id_uses_rs`=1 for 4 cycles → `hazard_err`=1 on the 5th cycle; it stays 1 after `pause` returns to 00.
- Preload `stall_cycles` near saturation via repeated stalls (`CNT_W`=4, 16 stall cycles) → counter holds at 15.
- Assert `rst`=0 mid-stall, asynchronously → `stalling`, counters and `hazard_err` read 0 before the next clock edge.
